// File: rtl/mult_ctrl.sv
// Sequential 32x32 shift-add multiplier for HI/LO with cancel and mthi/mtlo access.
// Optional signed (MULT) support is enabled by defining MULT_SIGNED_EN.
module mult_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplr;
  logic [4:0]  r_cnt;
  logic        r_neg;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_run;
  logic        w_last;
  logic [63:0] w_sum;
  logic [63:0] w_prod;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_neg;

`ifdef MULT_SIGNED_EN
  // Magnitudes as unsigned 32-bit values; -2^31 maps cleanly to 0x80000000.
  assign w_mag_a = (is_signed && a[31]) ? (~a + 32'd1) : a;
  assign w_mag_b = (is_signed && b[31]) ? (~b + 32'd1) : b;
  assign w_neg   = is_signed & (a[31] ^ b[31]);
`else
  logic w_unused_is_signed;
  assign w_unused_is_signed = is_signed;
  assign w_mag_a = a;
  assign w_mag_b = b;
  assign w_neg   = 1'b0;
`endif

  assign w_run    = (r_state == S_RUN);
  assign w_accept = start && !w_run;
  assign w_last   = w_run && !cancel && (r_cnt == 5'd31);
  assign w_sum    = r_acc + (r_mplr[0] ? r_mcand : 64'd0);
  assign w_prod   = r_neg ? (~w_sum + 64'd1) : w_sum;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        // Cancel wins over the completion edge.
        if (cancel)                  w_state_next = S_IDLE;
        else if (r_cnt == 5'd31)     w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = start ? S_RUN : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc   <= 64'd0;
      r_mcand <= 64'd0;
      r_mplr  <= 32'd0;
      r_cnt   <= 5'd0;
      r_neg   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= 64'd0;
      r_mcand <= {32'd0, w_mag_a};
      r_mplr  <= w_mag_b;
      r_cnt   <= 5'd0;
      r_neg   <= w_neg;
    end else if (w_run) begin
      r_acc   <= w_sum;
      r_mcand <= {r_mcand[62:0], 1'b0};
      r_mplr  <= {1'b0, r_mplr[31:1]};
      r_cnt   <= r_cnt + 5'd1;
    end
  end

  // The completion write includes the final partial product from this edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_last) begin
      r_hi <= w_prod[63:32];
      r_lo <= w_prod[31:0];
    end else if (!w_run) begin
      if (mthi) r_hi <= wdata;
      if (mtlo) r_lo <= wdata;
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: scoreboard of expected {hi,lo} per accepted start,
// compared whenever done pulses; latency, busy width, cancel, reset and mthi/mtlo checks.
module tb_mult_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb_q[$];

  mult_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .cancel    (cancel),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    logic [63:0] ux;
    logic [63:0] uy;
    logic        unused_s;
    unused_s = s;
    ux = {32'd0, x};
    uy = {32'd0, y};
`ifdef MULT_SIGNED_EN
    if (s) begin
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
`endif
    return ux * uy;
  endfunction

  // Result monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rstn && done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        logic [63:0] exp;
        exp = sb_q.pop_front();
        chk("result", {hi, lo}, exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Runs one operation; returns in the DONE cycle (state still DONE).
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                       input bit with_mt, input bit poke);
    int          edges;
    int          busy_cnt;
    logic [31:0] h_prev;
    start     = 1'b1;
    a         = ta;
    b         = tb_v;
    is_signed = ts;
    if (with_mt) begin
      mthi  = 1'b1;
      mtlo  = 1'b1;
      wdata = 32'hDEADBEEF;
    end
    sb_q.push_back(ref_mul(ta, tb_v, ts));
    tick();
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    edges = 1;
    busy_cnt = 0;
    h_prev = hi;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    if (with_mt) chk("mt_with_start", {hi, lo}, 64'hDEADBEEF_DEADBEEF);
    while (!done && edges < 40) begin
      if (busy) busy_cnt++;
      if (poke && edges == 10) begin
        h_prev = hi;
        start  = 1'b1;
        a      = 32'd0;
        b      = 32'd0;
        mthi   = 1'b1;
        wdata  = 32'h12345678;
      end
      tick();
      edges++;
      if (poke && edges == 11) begin
        start = 1'b0;
        mthi  = 1'b0;
        chk("mthi_in_run", {32'd0, hi}, {32'd0, h_prev});
      end
    end
    chk("latency", 64'(edges), 64'd33);
    chk("busy_cycles", 64'(busy_cnt), 64'd32);
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    mthi = 1'b1; wdata = h;
    tick();
    mthi = 1'b0; mtlo = 1'b1; wdata = l;
    tick();
    mtlo = 1'b0;
    chk("mt_write", {hi, lo}, {h, l});
  endtask

  // Starts a*b (not expected to finish) and cancels during the given RUN cycle.
  task automatic cancel_op(input int run_cycle);
    logic [31:0] h_prev;
    logic [31:0] l_prev;
    h_prev = hi;
    l_prev = lo;
    start = 1'b1; a = 32'd5; b = 32'd7; is_signed = 1'b0;
    tick();
    start = 1'b0;
    idle(run_cycle - 1);
    chk("busy_before_cancel", {63'd0, busy}, 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    chk("cancel_done", {63'd0, done}, 64'd0);
    chk("cancel_hilo", {hi, lo}, {h_prev, l_prev});
    idle(36);
    chk("cancel_hilo_late", {hi, lo}, {h_prev, l_prev});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    idle(3);
    chk("reset_state", {60'd0, busy, done, 2'b00}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    rstn = 1'b1;

    // All-ones unsigned: fixed expected constants plus scoreboard.
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    chk("ffxff", {hi, lo}, 64'hFFFFFFFE_00000001);
    tick();
    chk("done_one_cycle", {62'd0, busy, done}, 64'd0);

    do_op(32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, 1'b0);
`ifdef MULT_SIGNED_EN
    chk("m2x3_signed", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
`else
    chk("m2x3_unsigned", {hi, lo}, 64'h00000002_FFFFFFFA);
`endif
    tick();
    do_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0);
    chk("min_x_min", {hi, lo}, 64'h40000000_00000000);
    tick();

    // Start pulse and mthi mid-RUN ignored.
    do_op(32'h0001_0003, 32'h0000_0101, 1'b0, 1'b0, 1'b1);
    tick();

    // mthi/mtlo with start, then back-to-back (start held in DONE).
    do_op(32'd1234567, 32'd7654321, 1'b0, 1'b1, 1'b0);
    do_op(32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    do_op(32'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_then_idle", {62'd0, busy, done}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      do_op($urandom, $urandom, 1'(i % 2), 1'b0, 1'b0);
      idle(1 + (i % 2));
    end

    write_hilo(32'hAAAA5555, 32'h1234ABCD);
    cancel_op(10);
    cancel_op(32);

    // Asynchronous reset mid-RUN, then a fresh op on the first edge after release.
    write_hilo(32'h0BAD0BAD, 32'h600DF00D);
    start = 1'b1; a = 32'd9; b = 32'd9; is_signed = 1'b0;
    tick();
    start = 1'b0;
    idle(19);
    rstn = 1'b0;
    #1;
    chk("rst_outputs", {60'd0, busy, done, 2'b00}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    tick();
    rstn = 1'b1;
    do_op(32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    chk("after_reset_3x4", {hi, lo}, 64'd12);
    idle(3);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Port `clk`, input, 1 bit: rising-edge clock for all state.
REQ-003 Port `rstn`, input, 1 bit: asynchronous active-low reset.
REQ-004 Port `start`, input, 1 bit: request a multiply; sampled in IDLE or DONE only.
REQ-005 Port `is_signed`, input, 1 bit: 1 = MULT (two's complement), 0 = MULTU; sampled with `start`.
REQ-006 Port `a`, input, 32 bits: multiplicand; sampled with `start`.
REQ-007 Port `b`, input, 32 bits: multiplier; sampled with `start`.
REQ-008 Port `cancel`, input, 1 bit: pipeline flush; aborts a running operation.
REQ-009 Port `mthi`, input, 1 bit: write `wdata` to HI.
REQ-010 Port `mtlo`, input, 1 bit: write `wdata` to LO.
REQ-011 Port `wdata`, input, 32 bits: data for `mthi`/`mtlo`.
REQ-012 Port `busy`, output, 1 bit: 1 while in RUN; the pipeline stalls on it.
REQ-013 Port `done`, output, 1 bit: one-cycle pulse while in DONE.
REQ-014 Port `hi`, output, 32 bits: HI register, product bits 63:32.
REQ-015 Port `lo`, output, 32 bits: LO register, product bits 31:0.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN and DONE, with `busy` = (state==RUN) and `done` = (state==DONE), both registered-state decodes.
REQ-017 An edge with `start`=1 in IDLE or DONE SHALL do the following:
- latch the operand magnitudes and the negate flag;
- clear the 64-bit accumulator and the 5-bit counter;
- enter RUN.
REQ-018 In RUN, each edge SHALL:
- add the shifted multiplicand to the accumulator when the current multiplier LSB is 1;
- shift the multiplicand left 1 (64-bit) and the multiplier right 1;
- increment the counter.
REQ-019 On the RUN edge where the counter equals 31, the block SHALL write {hi,lo} with the final product (negated if the negate flag is set) and enter DONE.
REQ-020 Latency SHALL be fixed at 33 edges from start acceptance to the DONE state, independent of operand values.
REQ-021 DONE SHALL last exactly one cycle, then go to IDLE, or to RUN if `start`=1 (back-to-back operation).
REQ-022 `start` asserted in RUN SHALL be ignored; it is not queued.
REQ-023 `cancel`=1 in RUN SHALL force IDLE on that edge, with no hi/lo write and no `done` pulse. `cancel` SHALL take priority over completion on the counter==31 edge.
REQ-024 `cancel` in IDLE or DONE SHALL have no effect; `start`+`cancel` together in IDLE SHALL start the operation.
REQ-025 `mthi`/`mtlo` SHALL write `hi`/`lo` on the edge when the state is not RUN. In RUN they SHALL be ignored.
REQ-026 `mthi` or `mtlo` coincident with `start` SHALL both take effect; the later product overwrites the written value.
REQ-027 `hi`/`lo` SHALL hold their values throughout RUN until the completion write.
REQ-028 Arithmetic SHALL be modulo 2^64; the accumulator SHALL never overflow for any 32x32 operands.

Reset
REQ-029 `rstn`=0 SHALL, asynchronously:
- set state to IDLE;
- set `busy`=0, `done`=0, `hi`=0, `lo`=0;
- set the accumulator, operand registers, counter and negate flag to 0.
REQ-030 Reset asserted mid-RUN SHALL abandon the operation, with no `done` pulse after release.
REQ-031 After `rstn` deasserts, the first edge SHALL be able to accept `start`.

Configuration
REQ-032 With macro `MULT_SIGNED_EN` defined, `is_signed`=1 SHALL have the following effect:
- operands are converted to magnitudes (0x80000000 magnitude = 2^31);
- the negate flag is set to a[31]^b[31];
- the final 64-bit product is two's-complement negated when the flag is set.
REQ-033 Without `MULT_SIGNED_EN`, `is_signed` SHALL be ignored and every operation SHALL be unsigned; latency is unchanged.

Verification
REQ-034 Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0 -> `done` 33 edges after start; hi=0xFFFFFFFE, lo=0x00000001; `busy` high for exactly 32 cycles.
REQ-035 Signed (MULT_SIGNED_EN): a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. a=b=0x80000000 -> hi=0x40000000, lo=0. Without the macro, a=0xFFFFFFFE, b=3, is_signed=1 -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-036 Cancel: start a=5, b=7, then `cancel` on RUN cycle 10 -> IDLE next cycle, no `done` pulse, hi/lo keep their prior values. Repeat with `cancel` on the counter==31 edge -> same result.
REQ-037 Back-to-back and ignore:
- `start` held in DONE starts a second operation with no IDLE cycle; the second result is correct.
- `start` pulsed mid-RUN is ignored.
- `mthi`=1 with wdata=0x12345678 mid-RUN leaves hi unchanged.
REQ-038 Reset: `rstn` low at RUN cycle 20 -> busy=0, done=0, hi=lo=0 immediately. After release, a new operation 3x4 -> lo=12, hi=0.
